snake_key_ctrl: RTL and testbench

//  Downstream consumer of the PS/2 keyboard decoder. Handshakes translated key codes out of it
//  (data_ready/read), keeps make events, drops break and error frames, and maps them to snake

---
 rtl/snake_key_ctrl_pkg.sv | 68 ++++++
 rtl/snake_key_ctrl_dir_fifo.sv | 68 ++++++
 rtl/snake_key_ctrl.sv | 118 +++++++++++
 tb/tb_snake_key_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/snake_key_ctrl_pkg.sv
// Shared key codes, direction codes, handshake state encodings and the key-to-direction map.
// Setting SNAKE_WASD_EN adds WASD letters (either case) as direction keys.
package snake_key_ctrl_pkg;

  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_UP    = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  localparam logic [7:0] KEY_RIGHT = 8'h90;
  localparam logic [7:0] KEY_LEFT  = 8'h91;
  localparam logic [7:0] KEY_UP    = 8'h92;
  localparam logic [7:0] KEY_DOWN  = 8'h93;
  localparam logic [7:0] KEY_SPACE = 8'h20;
  localparam logic [7:0] KEY_ENTER = 8'h0D;
  localparam logic [7:0] KEY_ESC   = 8'h1B;
`ifdef SNAKE_WASD_EN
  localparam logic [7:0] KEY_W_LC  = 8'h77;
  localparam logic [7:0] KEY_A_LC  = 8'h61;
  localparam logic [7:0] KEY_S_LC  = 8'h73;
  localparam logic [7:0] KEY_D_LC  = 8'h64;
  localparam logic [7:0] KEY_W_UC  = 8'h57;
  localparam logic [7:0] KEY_A_UC  = 8'h41;
  localparam logic [7:0] KEY_S_UC  = 8'h53;
  localparam logic [7:0] KEY_D_UC  = 8'h44;
`endif

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CAP  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  typedef struct packed {
    logic       vld;
    logic [1:0] dir;
  } dir_cand_t;

  typedef struct packed {
    logic [7:0] code;
    logic       released;
    logic       err;
  } key_evt_t;

  function automatic dir_cand_t map_dir(input logic [7:0] code);
    dir_cand_t c;
    c.vld = 1'b0;
    c.dir = DIR_RIGHT;
    case (code)
      KEY_RIGHT: begin c.vld = 1'b1; c.dir = DIR_RIGHT; end
      KEY_LEFT:  begin c.vld = 1'b1; c.dir = DIR_LEFT;  end
      KEY_UP:    begin c.vld = 1'b1; c.dir = DIR_UP;    end
      KEY_DOWN:  begin c.vld = 1'b1; c.dir = DIR_DOWN;  end
`ifdef SNAKE_WASD_EN
      KEY_D_LC, KEY_D_UC: begin c.vld = 1'b1; c.dir = DIR_RIGHT; end
      KEY_A_LC, KEY_A_UC: begin c.vld = 1'b1; c.dir = DIR_LEFT;  end
      KEY_W_LC, KEY_W_UC: begin c.vld = 1'b1; c.dir = DIR_UP;    end
      KEY_S_LC, KEY_S_UC: begin c.vld = 1'b1; c.dir = DIR_DOWN;  end
`endif
      default: ;
    endcase
    return c;
  endfunction

  // Direction pairs differ only in bit 0, so flipping it yields the opposite heading.
  function automatic logic [1:0] reverse_of(input logic [1:0] d);
    return {d[1], ~d[0]};
  endfunction

endpackage

// File: rtl/snake_key_ctrl_dir_fifo.sv
// Direction queue: combinational head/tail, push and pop land on the same edge.
// A push while full is taken only when a pop frees a slot in the same cycle.
module dir_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [1:0] push_dat,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [1:0] head,
  output logic [1:0] tail
);

  logic [1:0]  mem_q [DEPTH];
  logic [1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];
  assign tail  = mem_q[wr_ptr_q - AW'(1)];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/snake_key_ctrl.sv
// Keyboard-to-snake command bridge: read pulses 1 cycle after data_ready, commands act 2 cycles after.
// Decoder holds its code until read; directions queue in dir_fifo. SNAKE_WASD_EN adds WASD keys.
module snake_key_ctrl
  import snake_key_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] scancode,
  input  logic       data_ready,
  input  logic       released,
  input  logic       err_ind,
  output logic       read,
  input  logic       tick,
  output logic [1:0] dir,
  output logic       dir_chg,
  output logic       start_p,
  output logic       paused,
  output logic       ovf,
  output logic [7:0] err_cnt
);

  logic [1:0] state_q, state_d;
  key_evt_t   evt_q, evt_d;
  logic       dec_vld_q, dec_vld_d;
  logic [1:0] dir_q, dir_d;
  logic       dir_chg_q, dir_chg_d;
  logic       paused_q, paused_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [1:0] fifo_head, fifo_tail;
  logic       key_ok, cand_ok;
  dir_cand_t  cand;
  logic [1:0] dir_ref;

  always_comb begin
    state_d   = state_q;
    evt_d     = evt_q;
    dec_vld_d = 1'b0;
    case (state_q)
      ST_IDLE: if (data_ready) state_d = ST_CAP;
      ST_CAP: begin
        state_d   = ST_DROP;
        evt_d     = '{code: scancode, released: released, err: err_ind};
        dec_vld_d = 1'b1;
      end
      ST_DROP: if (!data_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Reversal is judged against the newest queued heading, not the committed one.
  assign key_ok  = dec_vld_q && !evt_q.err && !evt_q.released;
  assign cand    = map_dir(evt_q.code);
  assign dir_ref = fifo_empty ? dir_q : fifo_tail;
  assign cand_ok = key_ok && cand.vld && (cand.dir != dir_ref) &&
                   (cand.dir != reverse_of(dir_ref));

  assign fifo_pop  = tick && !paused_q && !fifo_empty;
  assign fifo_push = cand_ok && (!fifo_full || fifo_pop);

  always_comb begin
    dir_d     = fifo_pop ? fifo_head : dir_q;
    dir_chg_d = fifo_pop;
    paused_d  = paused_q ^ (key_ok && (evt_q.code == KEY_ESC));
    err_cnt_d = err_cnt_q;
    if (dec_vld_q && evt_q.err && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      evt_q     <= '0;
      dec_vld_q <= 1'b0;
      dir_q     <= DIR_RIGHT;
      dir_chg_q <= 1'b0;
      paused_q  <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      evt_q     <= evt_d;
      dec_vld_q <= dec_vld_d;
      dir_q     <= dir_d;
      dir_chg_q <= dir_chg_d;
      paused_q  <= paused_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  dir_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_dir_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_dat (cand.dir),
    .pop      (fifo_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head),
    .tail     (fifo_tail)
  );

  assign read    = (state_q == ST_CAP);
  assign dir     = dir_q;
  assign dir_chg = dir_chg_q;
  assign paused  = paused_q;
  assign err_cnt = err_cnt_q;
  assign start_p = key_ok && ((evt_q.code == KEY_SPACE) || (evt_q.code == KEY_ENTER));
  assign ovf     = cand_ok && fifo_full && !fifo_pop;

endmodule

// File: tb/tb_snake_key_ctrl.sv
// Directed bench for snake_key_ctrl: hand-computed expectations checked with immediate assertions.
module tb_snake_key_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] scancode;
  logic       data_ready, released, err_ind, tick;
  logic       read, dir_chg, start_p, paused, ovf;
  logic [1:0] dir;
  logic [7:0] err_cnt;

  int compared = 0;
  int failed   = 0;
  int n_read, n_start, n_ovf, read_at;

  always #5 clk = ~clk;

  snake_key_ctrl #(.DEPTH(4), .AW(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .scancode   (scancode),
    .data_ready (data_ready),
    .released   (released),
    .err_ind    (err_ind),
    .read       (read),
    .tick       (tick),
    .dir        (dir),
    .dir_chg    (dir_chg),
    .start_p    (start_p),
    .paused     (paused),
    .ovf        (ovf),
    .err_cnt    (err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Presents one code, drops data_ready `hold` cycles after the read, and tallies pulses.
  task automatic send_key(input logic [7:0] c, input logic r, input logic e, input int hold);
    scancode   = c;
    released   = r;
    err_ind    = e;
    data_ready = 1'b1;
    n_read = 0; n_start = 0; n_ovf = 0; read_at = -1;
    for (int i = 0; i < hold + 5; i++) begin
      @(posedge clk); #1;
      if (read) begin
        n_read++;
        if (read_at < 0) read_at = i;
      end
      if (start_p) n_start++;
      if (ovf) n_ovf++;
      if (i == hold) data_ready = 1'b0;
    end
  endtask

  task automatic do_tick(input logic [1:0] exp_dir, input logic exp_chg, input string tag);
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    chk({tag, "_dir"}, dir, exp_dir);
    chk({tag, "_chg"}, dir_chg, exp_chg);
  endtask

  initial begin
    rst = 1'b0; scancode = 8'h00; data_ready = 1'b0; released = 1'b0;
    err_ind = 1'b0; tick = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_read", read, 0);
    chk("rst_dir", dir, 0);
    chk("rst_dir_chg", dir_chg, 0);
    chk("rst_start_p", start_p, 0);
    chk("rst_paused", paused, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_err_cnt", err_cnt, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Single up make, then a tick commits it.
    send_key(8'h92, 0, 0, 1);
    chk("t1_read_cnt", n_read, 1);
    chk("t1_read_lat", read_at, 0);
    chk("t1_ovf", n_ovf, 0);
    do_tick(2'd2, 1'b1, "t1_tick");
    @(posedge clk); #1;
    chk("t1_chg_once", dir_chg, 0);

    // Back to right, then reversal and duplicate are both rejected.
    send_key(8'h90, 0, 0, 1);
    do_tick(2'd0, 1'b1, "t2_right");
    send_key(8'h91, 0, 0, 1);
    chk("t2_rev_ovf", n_ovf, 0);
    send_key(8'h90, 0, 0, 1);
    chk("t2_dup_ovf", n_ovf, 0);
    do_tick(2'd0, 1'b0, "t2_tick");

    // Fill the queue: up, left, down, right fit; the fifth (up) overflows.
    send_key(8'h92, 0, 0, 1);
    send_key(8'h91, 0, 0, 1);
    send_key(8'h93, 0, 0, 1);
    send_key(8'h90, 0, 0, 1);
    chk("t3_4th_ovf", n_ovf, 0);
    send_key(8'h92, 0, 0, 1);
    chk("t3_5th_ovf", n_ovf, 1);
    do_tick(2'd2, 1'b1, "t3_pop1");
    do_tick(2'd1, 1'b1, "t3_pop2");
    do_tick(2'd3, 1'b1, "t3_pop3");
    do_tick(2'd0, 1'b1, "t3_pop4");
    do_tick(2'd0, 1'b0, "t3_empty");

    // Break and error frames are discarded; errors are counted with saturation.
    send_key(8'h92, 1, 0, 1);
    send_key(8'h92, 0, 1, 1);
    chk("t4_err_cnt1", err_cnt, 1);
    do_tick(2'd0, 1'b0, "t4_tick");
    for (int k = 0; k < 253; k++) send_key(8'h92, 0, 1, 1);
    chk("t4_err_cnt254", err_cnt, 254);
    for (int k = 0; k < 3; k++) send_key(8'h92, 0, 1, 1);
    chk("t4_err_sat", err_cnt, 255);

    // Pause holds the queue without flushing it.
    send_key(8'h1B, 0, 0, 1);
    chk("t5_paused_on", paused, 1);
    send_key(8'h92, 0, 0, 1);
    do_tick(2'd0, 1'b0, "t5_paused_tick");
    send_key(8'h1B, 0, 0, 1);
    chk("t5_paused_off", paused, 0);
    do_tick(2'd2, 1'b1, "t5_resume");
    send_key(8'h20, 0, 0, 1);
    chk("t5_space", n_start, 1);
    send_key(8'h0D, 0, 0, 1);
    chk("t5_enter", n_start, 1);
    send_key(8'h55, 0, 0, 4);
    chk("t5_hold_reads", n_read, 1);
    chk("t5_hold_start", n_start, 0);

    // Letter keys only steer when WASD support is built in.
    send_key(8'h61, 0, 0, 1);
`ifdef SNAKE_WASD_EN
    do_tick(2'd1, 1'b1, "t6_a");
`else
    do_tick(2'd2, 1'b0, "t6_a");
`endif
    send_key(8'h77, 0, 0, 1);
`ifdef SNAKE_WASD_EN
    do_tick(2'd2, 1'b1, "t6_w");
`else
    do_tick(2'd2, 1'b0, "t6_w");
`endif

    // Reset mid-handshake with two entries queued and pause set.
    send_key(8'h1B, 0, 0, 1);
    chk("t6_paused_pre", paused, 1);
    send_key(8'h91, 0, 0, 1);
    send_key(8'h93, 0, 0, 1);
    chk("t6_q_ovf", n_ovf, 0);
    scancode = 8'h55; released = 1'b0; err_ind = 1'b0; data_ready = 1'b1;
    @(posedge clk); #1;
    chk("t6_cap_read", read, 1);
    @(posedge clk); #1;
    rst = 1'b0; data_ready = 1'b0;
    @(posedge clk); #1;
    chk("t6_rst_read", read, 0);
    chk("t6_rst_dir", dir, 0);
    chk("t6_rst_dir_chg", dir_chg, 0);
    chk("t6_rst_start_p", start_p, 0);
    chk("t6_rst_paused", paused, 0);
    chk("t6_rst_ovf", ovf, 0);
    chk("t6_rst_err_cnt", err_cnt, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    do_tick(2'd0, 1'b0, "t6_post_empty");
    send_key(8'h92, 0, 0, 1);
    chk("t6_post_read", n_read, 1);
    do_tick(2'd2, 1'b1, "t6_post_up");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
